// File: rtl/dla_clock_cross_handshake_src_ctrl.sv
// Source-side controller for a four-phase req/ack clock-domain crossing.
// Holds a payload on a quasi-static bus, lets it settle, then runs the
// req/ack handshake. It also counts completed transfers and flags ack
// timeouts and protocol errors.
module dla_clock_cross_handshake_src_ctrl #(
  parameter int unsigned WIDTH          = 32,
  parameter int unsigned SETTLE_CYCLES  = 2,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic             clk,
  input  logic             i_sclr,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_ready,
  output logic [WIDTH-1:0] o_xfer_data,
  output logic             o_req,
  input  logic             i_ack_sync,
  output logic             o_done,
  output logic [31:0]      o_xfer_count,
  output logic             o_timeout,
  output logic             o_proto_err
);

  localparam logic [7:0]  SettleLast = 8'(SETTLE_CYCLES);
  localparam logic [31:0] TimeoutLim = 32'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    StIdle,
    StSettle,
    StReqHi,
    StReqLo
  } state_e;

  state_e           state_q, state_d;
  logic [7:0]       settle_cnt_q, settle_cnt_d;
  logic [31:0]      wait_cnt_q, wait_cnt_d;
  logic [31:0]      wait_cnt_inc;
  logic [WIDTH-1:0] xfer_data_q, xfer_data_d;
  logic             req_q, req_d;
  logic             done_q, done_d;
  logic [31:0]      xfer_count_q, xfer_count_d;
  logic             timeout_q, timeout_d;
  logic             proto_err_q, proto_err_d;

  // Saturating increment so a stuck ack never wraps the wait counter.
  assign wait_cnt_inc = (wait_cnt_q == 32'hFFFF_FFFF) ? wait_cnt_q : wait_cnt_q + 32'd1;

  // Next-state and registered-output logic for the handshake FSM.
  always_comb begin
    state_d      = state_q;
    settle_cnt_d = settle_cnt_q;
    wait_cnt_d   = wait_cnt_q;
    xfer_data_d  = xfer_data_q;
    req_d        = req_q;
    done_d       = 1'b0;
    xfer_count_d = xfer_count_q;
    timeout_d    = timeout_q;
    proto_err_d  = proto_err_q;

    case (state_q)
      StIdle: begin
        // A stale ack here is flagged but otherwise ignored.
        if (i_ack_sync) proto_err_d = 1'b1;
        if (i_valid) begin
          xfer_data_d  = i_data;
          settle_cnt_d = 8'd0;
          state_d      = StSettle;
        end
      end
      StSettle: begin
        if (settle_cnt_q == SettleLast) begin
          // Ack still high from a previous handshake: flag and stall.
          if (i_ack_sync) begin
            proto_err_d = 1'b1;
          end else begin
            req_d      = 1'b1;
            wait_cnt_d = 32'd0;
            state_d    = StReqHi;
          end
        end else begin
          settle_cnt_d = settle_cnt_q + 8'd1;
        end
      end
      StReqHi: begin
        if (i_ack_sync) begin
          req_d      = 1'b0;
          wait_cnt_d = 32'd0;
          state_d    = StReqLo;
        end else begin
          wait_cnt_d = wait_cnt_inc;
        end
      end
      StReqLo: begin
        if (!i_ack_sync) begin
          done_d       = 1'b1;
          xfer_count_d = xfer_count_q + 32'd1;
          state_d      = StIdle;
        end else begin
          wait_cnt_d = wait_cnt_inc;
        end
      end
      default: state_d = StIdle;
    endcase

    // Timeout only reports; the FSM keeps waiting for the ack.
    if ((TIMEOUT_CYCLES != 0) && ((state_q == StReqHi) || (state_q == StReqLo)) &&
        (wait_cnt_d == TimeoutLim)) begin
      timeout_d = 1'b1;
    end
  end

  // State register with synchronous active-high clear.
  always_ff @(posedge clk) begin
    if (i_sclr) begin
      state_q      <= StIdle;
      settle_cnt_q <= 8'd0;
      wait_cnt_q   <= 32'd0;
      xfer_data_q  <= '0;
      req_q        <= 1'b0;
      done_q       <= 1'b0;
      xfer_count_q <= 32'd0;
      timeout_q    <= 1'b0;
      proto_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      settle_cnt_q <= settle_cnt_d;
      wait_cnt_q   <= wait_cnt_d;
      xfer_data_q  <= xfer_data_d;
      req_q        <= req_d;
      done_q       <= done_d;
      xfer_count_q <= xfer_count_d;
      timeout_q    <= timeout_d;
      proto_err_q  <= proto_err_d;
    end
  end

  // o_ready is decoded from state alone so it never depends on i_valid.
  assign o_ready      = (state_q == StIdle);
  assign o_xfer_data  = xfer_data_q;
  assign o_req        = req_q;
  assign o_done       = done_q;
  assign o_xfer_count = xfer_count_q;
  assign o_timeout    = timeout_q;
  assign o_proto_err  = proto_err_q;

endmodule
